axi_burst_traffic_gen: RTL

//  Parametrised AXI4 master traffic generator/checker, next generation of the M00_AXI burst tester in acc_ip.

---
 rtl/axi_tg_pkg.sv | 30 +++
 rtl/axi_tg_pattern_gen.sv | 36 +++
 rtl/axi_burst_traffic_gen.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_tg_pkg.sv
// Shared types and constants for the AXI burst traffic generator:
// FSM state encoding, AXI response/burst codes, LFSR taps and a clog2 helper.
package axi_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } tg_state_t;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;

    function automatic int tg_clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_tg_pattern_gen.sv
// Data pattern source: a counter starting at 1 or a Galois LFSR, reseeded by load,
// stepped by advance; the 32-bit word is replicated across the data bus.
module axi_tg_pattern_gen #(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] SEED       = 32'hACE1_0001
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  advance,
    input  logic                  mode,
    output logic [DATA_WIDTH-1:0] data
);
    import axi_tg_pkg::*;

    logic [31:0] count;
    logic [31:0] lfsr;
    logic [31:0] word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 32'd1;
            lfsr  <= SEED;
        end else if (load) begin
            count <= 32'd1;
            lfsr  <= SEED;
        end else if (advance) begin
            count <= count + 32'd1;
            lfsr  <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
        end
    end

    assign word = mode ? lfsr : count;
    assign data = {(DATA_WIDTH/32){word}};

endmodule

// File: rtl/axi_burst_traffic_gen.sv
// AXI4 master burst tester: on a start edge writes N INCR bursts of a selectable
// pattern, reads them back, and reports done, sticky error and a saturating error count.
module axi_burst_traffic_gen
    import axi_tg_pkg::*;
#(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter int          C_M_AXI_BURST_LEN          = 16,
    parameter int          C_NO_BURSTS_REQ            = 4,
    parameter logic [31:0] C_LFSR_SEED                = 32'hACE1_0001
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            INIT_AXI_TXN,
    input  logic                            PATTERN_MODE,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [15:0]                     ERR_COUNT,
    output logic                            BUSY,
    output logic [2:0]                      dbg_state,

    output logic                            M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic                            M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARLOCK,
    output logic [3:0]                      M_AXI_ARCACHE,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int AW      = C_M_AXI_ADDR_WIDTH;
    localparam int DW      = C_M_AXI_DATA_WIDTH;
    localparam int BURST_W = tg_clog2(C_NO_BURSTS_REQ) + 1;

    localparam logic [AW-1:0]      BASE_ADDR   = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [AW-1:0]      BURST_BYTES = AW'(C_M_AXI_BURST_LEN * (DW / 8));
    localparam logic [7:0]         LAST_BEAT   = 8'(C_M_AXI_BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST  = BURST_W'(C_NO_BURSTS_REQ - 1);

    tg_state_t          state;
    tg_state_t          next_state;
    logic               init_q;
    logic               start;
    logic [AW-1:0]      addr;
    logic [7:0]         beat_cnt;
    logic [BURST_W-1:0] burst_cnt;
    logic               mode_q;
    logic               done_q;
    logic               error_q;
    logic [15:0]        err_cnt;
    logic [1:0]         err_inc;
    logic [16:0]        err_sum;
    logic               last_beat;
    logic               last_burst;
    logic               w_fire;
    logic               b_fire;
    logic               r_fire;
    logic [DW-1:0]      wr_data;
    logic [DW-1:0]      exp_data;

    // Valid/ready contract: a VALID this block drives rises without looking at READY and
    // stays high with its payload frozen until the cycle where VALID && READY both sample high.
    assign start      = INIT_AXI_TXN && !init_q && (state == ST_IDLE || state == ST_DONE);
    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign last_burst = (burst_cnt == LAST_BURST);
    assign w_fire     = M_AXI_WVALID && M_AXI_WREADY;
    assign b_fire     = M_AXI_BVALID && M_AXI_BREADY;
    assign r_fire     = M_AXI_RVALID && M_AXI_RREADY;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        BUSY          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_WR_ADDR;
            end
            ST_WR_ADDR: begin
                M_AXI_AWVALID = 1'b1;
                BUSY          = 1'b1;
                if (M_AXI_AWREADY) next_state = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                M_AXI_WVALID = 1'b1;
                BUSY         = 1'b1;
                if (M_AXI_WREADY && last_beat) next_state = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                BUSY         = 1'b1;
                if (M_AXI_BVALID) next_state = last_burst ? ST_RD_ADDR : ST_WR_ADDR;
            end
            ST_RD_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                BUSY          = 1'b1;
                if (M_AXI_ARREADY) next_state = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                M_AXI_RREADY = 1'b1;
                BUSY         = 1'b1;
                if (M_AXI_RVALID && last_beat) next_state = last_burst ? ST_DONE : ST_RD_ADDR;
            end
            ST_DONE: begin
                next_state = start ? ST_WR_ADDR : ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // A beat can add two errors: bad data/response plus an RLAST that disagrees with the beat count.
    always_comb begin
        err_inc = 2'd0;
        if (b_fire && M_AXI_BRESP != AXI_RESP_OKAY) begin
            err_inc = 2'd1;
        end
        if (r_fire) begin
            err_inc = 2'({1'b0, (M_AXI_RDATA != exp_data) || (M_AXI_RRESP != AXI_RESP_OKAY)})
                    + 2'({1'b0, M_AXI_RLAST != last_beat});
        end
        err_sum = {1'b0, err_cnt} + {15'd0, err_inc};
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            init_q    <= 1'b0;
            addr      <= BASE_ADDR;
            beat_cnt  <= 8'd0;
            burst_cnt <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_cnt   <= 16'd0;
        end else begin
            init_q <= INIT_AXI_TXN;
            if (start) begin
                addr      <= BASE_ADDR;
                beat_cnt  <= 8'd0;
                burst_cnt <= '0;
                mode_q    <= PATTERN_MODE;
                done_q    <= 1'b0;
                error_q   <= 1'b0;
                err_cnt   <= 16'd0;
            end else begin
                if (state == ST_DONE) done_q <= 1'b1;
                if (w_fire || r_fire) beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
                // The write pass wraps back to the base address so reads retrace the same bursts.
                if (b_fire || (r_fire && last_beat)) begin
                    if (last_burst) begin
                        burst_cnt <= '0;
                        addr      <= BASE_ADDR;
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                        addr      <= addr + BURST_BYTES;
                    end
                end
                if (err_inc != 2'd0) begin
                    error_q <= 1'b1;
                    err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                end
            end
        end
    end

    axi_tg_pattern_gen #(.DATA_WIDTH(DW), .SEED(C_LFSR_SEED)) u_wr_pattern (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .load    (start),
        .advance (w_fire),
        .mode    (mode_q),
        .data    (wr_data)
    );

    axi_tg_pattern_gen #(.DATA_WIDTH(DW), .SEED(C_LFSR_SEED)) u_exp_pattern (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .load    (b_fire && last_burst),
        .advance (r_fire),
        .mode    (mode_q),
        .data    (exp_data)
    );

    assign TXN_DONE  = done_q || (state == ST_DONE);
    assign ERROR     = error_q;
    assign ERR_COUNT = err_cnt;
    assign dbg_state = state;

    assign M_AXI_AWID    = 1'b0;
    assign M_AXI_AWADDR  = addr;
    assign M_AXI_AWLEN   = LAST_BEAT;
    assign M_AXI_AWSIZE  = 3'(tg_clog2(DW / 8));
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = 4'd0;
    assign M_AXI_AWPROT  = 3'd0;
    assign M_AXI_WDATA   = wr_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (state == ST_WR_DATA) && last_beat;

    assign M_AXI_ARID    = 1'b0;
    assign M_AXI_ARADDR  = addr;
    assign M_AXI_ARLEN   = LAST_BEAT;
    assign M_AXI_ARSIZE  = 3'(tg_clog2(DW / 8));
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'd0;
    assign M_AXI_ARPROT  = 3'd0;

endmodule
